instr_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the 8-bit processor. It sits between program/data memory, the combinational control unit and the register/PC/IO datapath. It fetches an instruction into its instruction register and drives the control unit's 5-bit opcode input. It then gates the control unit's raw enables into single, phase-correct strobes, handling wait states on memory and the IN/OUT ports.

---
 rtl/seq_pkg.sv | 44 ++++
 rtl/seq_watchdog.sv | 39 +++
 rtl/instr_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_instr_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the instruction sequencer:
//   - 4-bit opcode constants found in ir[7:4]
//   - 3-bit sequencer state enumeration (also exported on state_o)
//   - default watchdog wait limit
//   - decode helper mapping an opcode to the state that follows DECODE
// ---------------------------------------------------------------------------
package seq_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_ADD     = 4'h1;
  localparam logic [3:0] OP_LOAD    = 4'h2;
  localparam logic [3:0] OP_STORE   = 4'h3;
  localparam logic [3:0] OP_BR      = 4'h4;
  localparam logic [3:0] OP_IN      = 4'h5;
  localparam logic [3:0] OP_OUT     = 4'h6;
  localparam logic [3:0] OP_LOADIMM = 4'h7;
  localparam logic [3:0] OP_BR_Z    = 4'h8;
  localparam logic [3:0] OP_BR_N    = 4'h9;

  localparam int SEQ_WDOG_LIMIT_DEFAULT = 255;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_IO_IN  = 3'd4,
    ST_IO_OUT = 3'd5
  } state_t;

  // State entered after DECODE. Codes A-F fall through to FETCH like NOP.
  function automatic state_t seq_decode_next(input logic [3:0] op);
    case (op)
      OP_ADD, OP_LOADIMM, OP_BR, OP_BR_Z, OP_BR_N: return ST_EXEC;
      OP_LOAD, OP_STORE:                           return ST_MEM;
      OP_IN:                                       return ST_IO_IN;
      OP_OUT:                                      return ST_IO_OUT;
      default:                                     return ST_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// ---------------------------------------------------------------------------
// seq_watchdog
// Counts consecutive cycles in which the sequencer is stalled on a handshake
// and flags a timeout when the count reaches WDOG_LIMIT.
// Ports:
//   clk       in  : system clock
//   rst_n     in  : synchronous active-low reset
//   i_wait    in  : sequencer is waiting without its handshake this cycle
//   o_timeout out : count has reached WDOG_LIMIT (combinational, one cycle)
// ---------------------------------------------------------------------------
module seq_watchdog
  import seq_pkg::*;
#(
  parameter int WDOG_LIMIT = SEQ_WDOG_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_wait,
  output logic o_timeout
);

  logic [7:0] r_count;

  // Compare at full width so a limit above 255 never fires on wrap.
  assign o_timeout = (32'(r_count) == WDOG_LIMIT);

  // Any non-waiting cycle is a state change, so clearing on !i_wait covers
  // the "clear on state change" rule; a timeout restarts the count as well.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (o_timeout || !i_wait) begin
      r_count <= 8'd0;
    end else begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle fetch/decode/execute sequencer for the 8-bit processor. Holds
// the instruction register, drives the control unit opcode and turns the
// control unit's raw enables into phase-correct single strobes, absorbing
// wait states on memory and the IN/OUT ports.
//
// Optional feature: define SEQ_WATCHDOG_EN to bound every wait by
// WDOG_LIMIT cycles (timeout_err pulse, forced return to FETCH). Without it
// waits are unbounded and timeout_err is tied 0.
//
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   mem_rdata, mem_ready    : memory read data / access-complete
//   zero_flag, neg_flag     : ALU flags, sampled in DECODE for BR_Z / BR_N
//   cu_regWrite, cu_memWrite, cu_memRead, cu_WEinOut, cu_pcLine
//                           : raw control-unit enables
//   io_in_valid, io_out_ready : IO port handshakes
//   cu_op                   : {ir[7:4], cond} to the control unit
//   ir                      : instruction register
//   mem_re, mem_we, addr_sel: memory strobes, address source (1=operand)
//   pc_inc, pc_load         : PC increment / branch load
//   reg_we, out_we          : register file / output port writes
//   io_in_ack, io_out_valid : IO handshakes
//   state_o                 : current state (debug)
//   timeout_err             : one-cycle watchdog pulse
// ---------------------------------------------------------------------------
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int WDOG_LIMIT = SEQ_WDOG_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  input  logic       zero_flag,
  input  logic       neg_flag,
  input  logic       cu_regWrite,
  input  logic       cu_memWrite,
  input  logic       cu_memRead,
  input  logic       cu_WEinOut,
  input  logic       cu_pcLine,
  input  logic       io_in_valid,
  input  logic       io_out_ready,
  output logic [4:0] cu_op,
  output logic [7:0] ir,
  output logic       mem_re,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       reg_we,
  output logic       out_we,
  output logic       io_in_ack,
  output logic       io_out_valid,
  output logic [2:0] state_o,
  output logic       timeout_err
);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_ir;
  logic       r_cond;
  logic       w_load_ir;
  logic       w_timeout;
  logic [3:0] w_op;

  assign w_op    = r_ir[7:4];
  assign ir      = r_ir;
  assign cu_op   = {r_ir[7:4], r_cond};
  assign state_o = r_state;

`ifdef SEQ_WATCHDOG_EN
  logic w_wait;

  // Waiting = sitting in a handshake state without the handshake.
  assign w_wait = ((r_state == ST_FETCH)  && !mem_ready)   ||
                  ((r_state == ST_MEM)    && !mem_ready)   ||
                  ((r_state == ST_IO_IN)  && !io_in_valid) ||
                  ((r_state == ST_IO_OUT) && !io_out_ready);

  seq_watchdog #(
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wait   (w_wait),
    .o_timeout(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  assign timeout_err = w_timeout & rst_n;

  // Next state and Mealy strobes.
  always_comb begin
    w_state_next = r_state;
    w_load_ir    = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    reg_we       = 1'b0;
    out_we       = 1'b0;
    io_in_ack    = 1'b0;
    io_out_valid = 1'b0;

    case (r_state)
      ST_FETCH: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          pc_inc       = 1'b1;
          w_load_ir    = 1'b1;
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_state_next = seq_decode_next(w_op);
      end
      ST_EXEC: begin
        reg_we       = cu_regWrite;
        pc_load      = cu_pcLine;
        w_state_next = ST_FETCH;
      end
      ST_MEM: begin
        addr_sel = 1'b1;
        mem_re   = cu_memRead;
        mem_we   = cu_memWrite;
        if (mem_ready) begin
          reg_we       = cu_regWrite;
          w_state_next = ST_FETCH;
        end
      end
      ST_IO_IN: begin
        if (io_in_valid) begin
          io_in_ack    = 1'b1;
          reg_we       = cu_regWrite;
          w_state_next = ST_FETCH;
        end
      end
      ST_IO_OUT: begin
        io_out_valid = 1'b1;
        if (io_out_ready) begin
          out_we       = cu_WEinOut;
          w_state_next = ST_FETCH;
        end
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase

    // A timeout abandons the instruction: no strobe may leak out and the
    // pending fetch (if any) is not captured.
    // Reset likewise masks every strobe so nothing is partially written.
    if (w_timeout || !rst_n) begin
      w_load_ir    = 1'b0;
      mem_re       = 1'b0;
      mem_we       = 1'b0;
      addr_sel     = 1'b0;
      pc_inc       = 1'b0;
      pc_load      = 1'b0;
      reg_we       = 1'b0;
      out_we       = 1'b0;
      io_in_ack    = 1'b0;
      io_out_valid = 1'b0;
    end
    if (w_timeout) begin
      w_state_next = ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_ir    <= 8'h00;
      r_cond  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load_ir) begin
        r_ir   <= mem_rdata;
        // Clear so the new opcode is never paired with a stale condition.
        r_cond <= 1'b0;
      end else if (r_state == ST_DECODE) begin
        // Flags are sampled only here; later flag changes do not matter.
        r_cond <= (w_op == OP_BR_Z) ? zero_flag :
                  (w_op == OP_BR_N) ? neg_flag  : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Self-checking bench: directed scenarios with literal expectations followed
// by randomized stimulus, all compared every cycle against an instruction-
// level model (fetch phase / decode phase / work phase by instruction class).
// Define SEQ_WATCHDOG_EN to also build and exercise the watchdog (limit 4).
// ---------------------------------------------------------------------------
module tb_instr_sequencer;
  import seq_pkg::*;

`ifdef SEQ_WATCHDOG_EN
  localparam int WL = 4;
  localparam bit WD = 1'b1;
`else
  localparam int WL = 255;
  localparam bit WD = 1'b0;
`endif
  // An OUT stall as long as the limit would trip the watchdog first.
  localparam int OUT_STALL = WD ? 3 : 4;

  localparam int B_MEM_RE = 9, B_MEM_WE = 8, B_ADDR = 7, B_PCINC = 6, B_PCLOAD = 5;
  localparam int B_REGWE = 4, B_OUTWE = 3, B_ACK = 2, B_OVALID = 1, B_TMO = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] mem_rdata;
  logic       mem_ready, zero_flag, neg_flag;
  logic       cu_regWrite, cu_memWrite, cu_memRead, cu_WEinOut, cu_pcLine;
  logic       io_in_valid, io_out_ready;
  wire  [4:0] cu_op;
  wire  [7:0] ir;
  wire        mem_re, mem_we, addr_sel, pc_inc, pc_load, reg_we, out_we;
  wire        io_in_ack, io_out_valid, timeout_err;
  wire  [2:0] state_o;

  always #5 clk = ~clk;

  instr_sequencer #(.WDOG_LIMIT(WL)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .zero_flag(zero_flag), .neg_flag(neg_flag),
    .cu_regWrite(cu_regWrite), .cu_memWrite(cu_memWrite), .cu_memRead(cu_memRead),
    .cu_WEinOut(cu_WEinOut), .cu_pcLine(cu_pcLine),
    .io_in_valid(io_in_valid), .io_out_ready(io_out_ready),
    .cu_op(cu_op), .ir(ir), .mem_re(mem_re), .mem_we(mem_we), .addr_sel(addr_sel),
    .pc_inc(pc_inc), .pc_load(pc_load), .reg_we(reg_we), .out_we(out_we),
    .io_in_ack(io_in_ack), .io_out_valid(io_out_valid), .state_o(state_o),
    .timeout_err(timeout_err)
  );

  wire [9:0] dut_strb = {mem_re, mem_we, addr_sel, pc_inc, pc_load, reg_we,
                         out_we, io_in_ack, io_out_valid, timeout_err};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = fetching, 1 = decoding, 2 = doing the work of class m_cls.
  // Classes: 0 none, 1 single-cycle execute, 2 memory, 3 input, 4 output.
  int         m_step = 0;
  int         m_cls = 0;
  logic [7:0] m_ir = 8'h00;
  logic       m_cond = 1'b0;
  int         m_cnt = 0;
  bit         m_valid = 1'b0;

  logic [9:0] s_strb;
  logic [2:0] s_state;
  logic [7:0] s_ir;
  logic [4:0] s_cu_op;

  function automatic int cls_of(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd7, 4'd8, 4'd9: return 1;
      4'd2, 4'd3:                   return 2;
      4'd5:                         return 3;
      4'd6:                         return 4;
      default:                      return 0;
    endcase
  endfunction

  // One clock: sample and check mid-cycle, then advance the model at the edge.
  task automatic step();
    logic [9:0] e;
    logic [2:0] e_state;
    int         n_step, n_cls, n_cnt;
    logic [7:0] n_ir;
    logic       n_cond;
    bit         waiting, rst_seen;
    @(negedge clk);
    #1;
    s_strb = dut_strb; s_state = state_o; s_ir = ir; s_cu_op = cu_op;
    e = '0;
    n_step = m_step; n_cls = m_cls; n_cnt = m_cnt; n_ir = m_ir; n_cond = m_cond;
    rst_seen = !rst_n;
    if (!rst_n) begin
      chk("strobes_in_reset", 32'(dut_strb), 32'd0);
      n_step = 0; n_cls = 0; n_cnt = 0; n_ir = 8'h00; n_cond = 1'b0;
    end else if (m_valid) begin
      if (m_step == 0)      e_state = ST_FETCH;
      else if (m_step == 1) e_state = ST_DECODE;
      else if (m_cls == 1)  e_state = ST_EXEC;
      else if (m_cls == 2)  e_state = ST_MEM;
      else if (m_cls == 3)  e_state = ST_IO_IN;
      else                  e_state = ST_IO_OUT;
      waiting = (m_step == 0 && !mem_ready) ||
                (m_step == 2 && m_cls == 2 && !mem_ready) ||
                (m_step == 2 && m_cls == 3 && !io_in_valid) ||
                (m_step == 2 && m_cls == 4 && !io_out_ready);
      if (WD && m_cnt == WL) begin
        e[B_TMO] = 1'b1; n_step = 0; n_cnt = 0;
      end else begin
        if (m_step == 0) begin
          e[B_MEM_RE] = 1'b1;
          if (mem_ready) begin
            e[B_PCINC] = 1'b1; n_ir = mem_rdata; n_step = 1;
          end
        end else if (m_step == 1) begin
          n_cls  = cls_of(m_ir[7:4]);
          n_cond = (m_ir[7:4] == 4'd8) ? zero_flag : (m_ir[7:4] == 4'd9) ? neg_flag : 1'b0;
          n_step = (n_cls == 0) ? 0 : 2;
        end else if (m_cls == 1) begin
          e[B_REGWE] = cu_regWrite; e[B_PCLOAD] = cu_pcLine; n_step = 0;
        end else if (m_cls == 2) begin
          e[B_ADDR] = 1'b1; e[B_MEM_RE] = cu_memRead; e[B_MEM_WE] = cu_memWrite;
          if (mem_ready) begin e[B_REGWE] = cu_regWrite; n_step = 0; end
        end else if (m_cls == 3) begin
          if (io_in_valid) begin e[B_ACK] = 1'b1; e[B_REGWE] = cu_regWrite; n_step = 0; end
        end else begin
          e[B_OVALID] = 1'b1;
          if (io_out_ready) begin e[B_OUTWE] = cu_WEinOut; n_step = 0; end
        end
        n_cnt = waiting ? m_cnt + 1 : 0;
      end
      chk("strobes", 32'(dut_strb), 32'(e));
      chk("state_o", 32'(state_o), 32'(e_state));
      chk("ir", 32'(ir), 32'(m_ir));
      if (m_step == 1) chk("cu_op_decode", 32'(cu_op[4:1]), 32'(m_ir[7:4]));
      if (m_step == 2) chk("cu_op_work", 32'(cu_op), 32'({m_ir[7:4], m_cond}));
    end
    @(posedge clk);
    #1;
    if (rst_seen) m_valid = 1'b1;
    m_step = n_step; m_cls = n_cls; m_cnt = n_cnt; m_ir = n_ir; m_cond = n_cond;
  endtask

  initial begin
    int n_a, n_b, at;
    rst_n = 1'b0; mem_rdata = 8'h00; mem_ready = 1'b1; zero_flag = 1'b0; neg_flag = 1'b0;
    cu_regWrite = 1'b0; cu_memWrite = 1'b0; cu_memRead = 1'b0; cu_WEinOut = 1'b0;
    cu_pcLine = 1'b0; io_in_valid = 1'b0; io_out_ready = 1'b0;

    // Reset for two cycles with memory ready.
    step();
    step();
    chk("reset_state", 32'(s_state), 32'(ST_FETCH));
    chk("reset_ir", 32'(s_ir), 32'h00);
    chk("reset_strobes", 32'(s_strb), 32'd0);

    // ADD 0x12 with zero wait.
    rst_n = 1'b1; mem_rdata = 8'h12; mem_ready = 1'b1; cu_regWrite = 1'b1;
    step();
    chk("add_pc_inc_c1", 32'(s_strb[B_PCINC]), 32'd1);
    step();
    chk("add_cu_op_c2", 32'(s_cu_op[4:1]), 32'h1);
    chk("add_no_reg_we_c2", 32'(s_strb[B_REGWE]), 32'd0);
    step();
    chk("add_reg_we_c3", 32'(s_strb[B_REGWE]), 32'd1);
    chk("add_cu_op_c3", 32'(s_cu_op), 32'h02);
    mem_ready = 1'b0;
    step();
    chk("add_fetch_c4", 32'(s_state), 32'(ST_FETCH));
    chk("add_no_pc_inc_c4", 32'(s_strb[B_PCINC]), 32'd0);

    // LOAD 0x25 with two memory wait cycles.
    cu_memRead = 1'b1; mem_rdata = 8'h25; mem_ready = 1'b1;
    step();
    step();
    n_a = 0; n_b = 0; at = -1;
    for (int k = 0; k < 3; k++) begin
      mem_ready = (k == 2);
      step();
      if (s_strb[B_MEM_RE] && s_strb[B_ADDR]) n_a++;
      if (s_strb[B_REGWE]) begin n_b++; at = k; end
    end
    chk("load_mem_re_cycles", 32'(n_a), 32'd3);
    chk("load_reg_we_count", 32'(n_b), 32'd1);
    chk("load_reg_we_at", 32'(at), 32'd2);
    mem_ready = 1'b0; cu_memRead = 1'b0; cu_regWrite = 1'b0;
    step();

    // BR_Z 0x84: zero flag high in DECODE, low afterwards.
    cu_pcLine = 1'b1; zero_flag = 1'b1; mem_rdata = 8'h84; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    zero_flag = 1'b0;
    step();
    chk("brz_cu_op", 32'(s_cu_op), 32'h11);
    chk("brz_pc_load", 32'(s_strb[B_PCLOAD]), 32'd1);
    chk("brz_no_pc_inc", 32'(s_strb[B_PCINC]), 32'd0);
    cu_pcLine = 1'b0;

    // OUT 0x60 with the port stalled.
    cu_WEinOut = 1'b1; mem_rdata = 8'h60; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    n_a = 0; n_b = 0; at = -1;
    for (int k = 0; k <= OUT_STALL; k++) begin
      io_out_ready = (k == OUT_STALL);
      step();
      if (s_strb[B_OVALID]) n_a++;
      if (s_strb[B_OUTWE]) begin n_b++; at = k; end
    end
    chk("out_valid_cycles", 32'(n_a), 32'(OUT_STALL + 1));
    chk("out_we_count", 32'(n_b), 32'd1);
    chk("out_we_at", 32'(at), 32'(OUT_STALL));
    io_out_ready = 1'b0; cu_WEinOut = 1'b0;

`ifdef SEQ_WATCHDOG_EN
    // Memory stuck: a pulse after every four wait cycles, state stays FETCH.
    mem_ready = 1'b0;
    n_a = 0; n_b = -1; at = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (s_strb[B_TMO]) begin
        n_a++;
        if (n_b < 0) n_b = k; else at = k;
      end
      chk("wdog_state_fetch", 32'(s_state), 32'(ST_FETCH));
    end
    chk("wdog_pulses", 32'(n_a), 32'd2);
    chk("wdog_first_at", 32'(n_b), 32'd5);
    chk("wdog_second_at", 32'(at), 32'd10);
`else
    // No watchdog: a long stall never produces a timeout.
    mem_ready = 1'b0;
    n_a = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (s_strb[B_TMO]) n_a++;
    end
    chk("no_wdog_pulses", 32'(n_a), 32'd0);
`endif

    // Randomized traffic, including occasional mid-instruction resets.
    for (int k = 0; k < 4000; k++) begin
      rst_n        = ($urandom_range(0, 79) != 0);
      mem_rdata    = 8'($urandom);
      mem_ready    = ($urandom_range(0, 2) != 0);
      zero_flag    = 1'($urandom);
      neg_flag     = 1'($urandom);
      cu_regWrite  = 1'($urandom);
      cu_memWrite  = 1'($urandom);
      cu_memRead   = 1'($urandom);
      cu_WEinOut   = 1'($urandom);
      cu_pcLine    = 1'($urandom);
      io_in_valid  = ($urandom_range(0, 2) == 0);
      io_out_ready = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
